// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - unsigned 8x8 shift-and-add multiplier with start/done handshake
// The cla module is the carry-lookahead adder that the multiplier drives every cycle.

module cla (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c0,
  output logic [7:0] s,
  output logic       c_out
);

  logic [7:0] p;
  logic [7:0] g;
  logic [8:0] c;

  // Each carry is the flattened generate/propagate chain, so no signal feeds itself.
  function automatic logic [8:0] carries(input logic [7:0] pp, input logic [7:0] gg, input logic cin);
    logic [8:0] cc;
    cc[0] = cin;
    for (int i = 0; i < 8; i++) begin
      cc[i+1] = gg[i] | (pp[i] & cc[i]);
    end
    return cc;
  endfunction

  assign p     = a ^ b;
  assign g     = a & b;
  assign c     = carries(p, g, c0);
  assign s     = p ^ c[7:0];
  assign c_out = c[8];

endmodule

module seq_multiplier (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] m;
  logic [7:0] acc;
  logic [7:0] q;
  logic [3:0] cnt;

  logic [7:0] addend;
  logic [7:0] s;
  logic       c_out;

  assign addend = q[0] ? m : 8'h00;

  cla adder (
    .a     (acc),
    .b     (addend),
    .c0    (1'b0),
    .s     (s),
    .c_out (c_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      m       <= 8'h00;
      acc     <= 8'h00;
      q       <= 8'h00;
      cnt     <= 4'd0;
      product <= 16'h0000;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            m     <= a;
            q     <= b;
            acc   <= 8'h00;
            cnt   <= 4'd0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          // Shift the 9-bit sum right across {acc, q}; the product is taken from the same shifted value.
          acc <= {c_out, s[7:1]};
          q   <= {s[0], q[7:1]};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd7) begin
            product <= {c_out, s[7:1], s[0], q[7:1]};
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
